instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Sequential instruction fetcher feeding a 2-entry {PC, instr} buffer.
//   - Code memory answers one cycle after a request (oMemRead/oAddress).
//   - At most one request is in flight; the in-flight tag remembers its PC.
//   - A request is issued only if the buffer will still have room for its
//     response, so the buffer can never overflow.
//   - Redirect flushes the buffer, kills the in-flight response and restarts
//     fetch at iRedirectPC.
//   - An illegal fetch address (misaligned or >= MEM_TOP) halts fetching.
//     The halt is sticky until the next redirect or reset, and the offending
//     address is reported.
//
// Downstream handshake: oValid is a valid flag and !iStall is a ready flag.
// A head entry transfers (pops) in every cycle where oValid=1 and iStall=0.
// oInstr/oPC do not change while oValid=1 and iStall=1, unless a redirect
// or reset intervenes.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] MEM_TOP  = 32'h0000_6000
) (
   input  logic        iCLK,
   input  logic        iRST,
   output logic [31:0] oAddress,
   output logic        oMemRead,
   output logic [3:0]  oByteEnable,
   input  logic [31:0] iMemData,
   input  logic        iStall,
   input  logic        iRedirect,
   input  logic [31:0] iRedirectPC,
   output logic        oValid,
   output logic [31:0] oInstr,
   output logic [31:0] oPC,
   output logic        oFault,
   output logic [31:0] oFaultPC
);

   // fetch state
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        tag_valid_q, tag_valid_d;
   logic [31:0] tag_pc_q, tag_pc_d;
   logic        fault_q, fault_d;
   logic [31:0] fault_pc_q, fault_pc_d;
   logic [31:0] addr_q, addr_d;

   // two-entry circular buffer: rd_ptr points at the head
   logic [31:0] fifo_pc_q [2];
   logic [31:0] fifo_pc_d [2];
   logic [31:0] fifo_instr_q [2];
   logic [31:0] fifo_instr_d [2];
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;

   // per-cycle decisions
   logic        pop;
   logic        push;
   logic        pc_legal;
   logic        issue;
   logic        fault_detect;
   logic [2:0]  occupancy;
   logic        wr_idx;

   // Decide pop/issue/fault for this cycle from the current state and inputs.
   always_comb begin
      pop       = (count_q != 2'd0) && !iStall;
      push      = tag_valid_q;
      pc_legal  = (fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q < MEM_TOP);
      // slots the buffer will hold after this cycle's pop and the pending push
      occupancy = {1'b0, count_q} + {2'b00, tag_valid_q} - {2'b00, pop};
      issue        = !iRST && !iRedirect && !fault_q && pc_legal
                     && (occupancy < 3'd2);
      fault_detect = !iRST && !iRedirect && !fault_q && !pc_legal;
      // a push lands behind the current contents; with count=2 this is only
      // reachable together with a pop, so the freed head slot is reused
      wr_idx    = rd_ptr_q ^ count_q[0];
   end

   // Memory-side outputs: the request is combinational so the response
   // arrives in the very next cycle; the address otherwise holds.
   always_comb begin
      oMemRead    = issue;
      oAddress    = issue ? fetch_pc_q : addr_q;
      oByteEnable = 4'b1111;
   end

   // Next-state computation; redirect overrides stall, pop and push.
   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      tag_valid_d  = tag_valid_q;
      tag_pc_d     = tag_pc_q;
      fault_d      = fault_q;
      fault_pc_d   = fault_pc_q;
      addr_d       = oAddress;
      fifo_pc_d    = fifo_pc_q;
      fifo_instr_d = fifo_instr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;

      if (iRedirect) begin
         count_d     = 2'd0;
         tag_valid_d = 1'b0;
         fetch_pc_d  = iRedirectPC;
         fault_d     = 1'b0;
         fault_pc_d  = 32'd0;
      end else begin
         if (push) begin
            fifo_pc_d[wr_idx]    = tag_pc_q;
            fifo_instr_d[wr_idx] = iMemData;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};

         tag_valid_d = issue;
         if (issue) begin
            tag_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
         end

         if (fault_detect) begin
            fault_d    = 1'b1;
            fault_pc_d = fetch_pc_q;
         end
      end
   end

   // State registers with synchronous reset; reset beats any redirect or
   // response arriving in the same cycle.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         fetch_pc_q  <= RESET_PC;
         tag_valid_q <= 1'b0;
         tag_pc_q    <= 32'd0;
         fault_q     <= 1'b0;
         fault_pc_q  <= 32'd0;
         addr_q      <= 32'd0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_pc_q[i]    <= 32'd0;
            fifo_instr_q[i] <= 32'd0;
         end
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         tag_valid_q  <= tag_valid_d;
         tag_pc_q     <= tag_pc_d;
         fault_q      <= fault_d;
         fault_pc_q   <= fault_pc_d;
         addr_q       <= addr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         fifo_pc_q    <= fifo_pc_d;
         fifo_instr_q <= fifo_instr_d;
      end
   end

   // Downstream outputs come straight from the buffer head and fault flops.
   always_comb begin
      oValid   = (count_q != 2'd0);
      oInstr   = fifo_instr_q[rd_ptr_q];
      oPC      = fifo_pc_q[rd_ptr_q];
      oFault   = fault_q;
      oFaultPC = fault_pc_q;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Queue-based reference model of the fetch unit, checked every cycle,
//   plus directed scenarios with hand-computed expectations and a
//   randomized stall/redirect/reset phase. Code memory: word at byte
//   address a is a>>2.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] MEM_TOP  = 32'h0000_6000;

   // clock / reset
   logic iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   logic        iRST;
   logic [31:0] oAddress;
   logic        oMemRead;
   logic [3:0]  oByteEnable;
   logic [31:0] iMemData;
   logic        iStall;
   logic        iRedirect;
   logic [31:0] iRedirectPC;
   logic        oValid;
   logic [31:0] oInstr;
   logic [31:0] oPC;
   logic        oFault;
   logic [31:0] oFaultPC;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .MEM_TOP(MEM_TOP)) dut (
      .iCLK        (iCLK),
      .iRST        (iRST),
      .oAddress    (oAddress),
      .oMemRead    (oMemRead),
      .oByteEnable (oByteEnable),
      .iMemData    (iMemData),
      .iStall      (iStall),
      .iRedirect   (iRedirect),
      .iRedirectPC (iRedirectPC),
      .oValid      (oValid),
      .oInstr      (oInstr),
      .oPC         (oPC),
      .oFault      (oFault),
      .oFaultPC    (oFaultPC)
   );

   int tests = 0;
   int fails = 0;

   // reference model: buffered {pc, instr} entries, fetch pointer, one in-flight slot
   logic [63:0] exp_q[$];
   logic [31:0] m_pc;
   bit          m_infl;
   logic [31:0] m_infl_pc;
   bit          m_fault;
   logic [31:0] m_fpc;
   logic [31:0] m_last_addr;

   // memory responder state
   bit          resp_pending = 1'b0;
   logic [31:0] resp_addr = 32'd0;

   // last sampled DUT outputs
   logic        s_valid, s_mr, s_fault;
   logic [31:0] s_pc, s_instr, s_addr, s_fpc;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a >> 2;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_pc        = RESET_PC;
      m_infl      = 1'b0;
      m_infl_pc   = 32'd0;
      m_fault     = 1'b0;
      m_fpc       = 32'd0;
      m_last_addr = 32'd0;
   endtask

   // driver + scoreboard: one clock cycle with the given inputs
   task automatic step(input bit rst, input bit redir, input logic [31:0] rpc, input bit stall);
      bit          e_valid, pop, legal, room, issue;
      logic [31:0] e_addr;
      @(negedge iCLK);
      iRST        = rst;
      iRedirect   = redir;
      iRedirectPC = rpc;
      iStall      = stall;
      iMemData    = resp_pending ? word_at(resp_addr) : $urandom;
      #1;
      s_valid = oValid;   s_pc  = oPC;      s_instr = oInstr;
      s_mr    = oMemRead; s_addr = oAddress;
      s_fault = oFault;   s_fpc = oFaultPC;

      e_valid = (exp_q.size() != 0);
      pop     = e_valid && !stall;
      legal   = (m_pc % 4 == 0) && (m_pc < MEM_TOP);
      room    = (exp_q.size() + int'(m_infl) - int'(pop)) < 2;
      issue   = !rst && !redir && !m_fault && legal && room;
      e_addr  = issue ? m_pc : m_last_addr;

      check("oValid", {31'd0, s_valid}, {31'd0, e_valid});
      if (e_valid) begin
         check("oPC", s_pc, exp_q[0][63:32]);
         check("oInstr", s_instr, exp_q[0][31:0]);
      end
      check("oMemRead", {31'd0, s_mr}, {31'd0, issue});
      check("oAddress", s_addr, e_addr);
      check("oFault", {31'd0, s_fault}, {31'd0, m_fault});
      check("oFaultPC", s_fpc, m_fpc);
      check("oByteEnable", {28'd0, oByteEnable}, 32'hF);

      resp_pending = s_mr;
      resp_addr    = s_addr;

      if (rst) begin
         model_reset();
      end else if (redir) begin
         exp_q.delete();
         m_infl  = 1'b0;
         m_pc    = rpc;
         m_fault = 1'b0;
         m_fpc   = 32'd0;
         m_last_addr = e_addr;
      end else begin
         if (pop) void'(exp_q.pop_front());
         if (m_infl) exp_q.push_back({m_infl_pc, word_at(m_infl_pc)});
         if (issue) begin
            m_infl    = 1'b1;
            m_infl_pc = m_pc;
            m_pc      = m_pc + 32'd4;
         end else begin
            m_infl = 1'b0;
         end
         if (!m_fault && !legal) begin
            m_fault = 1'b1;
            m_fpc   = m_pc;
         end
         m_last_addr = e_addr;
         check("model_depth_le2", {31'd0, exp_q.size() > 2}, 32'd0);
      end
   endtask

   function automatic logic [31:0] rand_target();
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
         0: rand_target = {$urandom_range(0, 32'h17FF), 2'b00} | 32'($urandom_range(1, 3));
         1: rand_target = MEM_TOP + {$urandom_range(0, 32'h3FFFFFF), 2'b00};
         2: rand_target = 32'h5FE0 + 32'($urandom_range(0, 7) * 4);
         default: rand_target = {14'd0, 16'($urandom_range(0, 32'h17FF)), 2'b00};
      endcase
   endfunction

   initial begin
      iRST = 1'b1; iRedirect = 1'b0; iRedirectPC = 32'd0; iStall = 1'b0; iMemData = 32'd0;
      repeat (3) @(posedge iCLK);
      model_reset();

      // reset state
      step(1, 0, 32'd0, 0);
      check("rst_oValid", {31'd0, s_valid}, 32'd0);
      check("rst_oInstr", s_instr, 32'd0);
      check("rst_oPC", s_pc, 32'd0);
      check("rst_oAddress", s_addr, 32'd0);
      check("rst_oMemRead", {31'd0, s_mr}, 32'd0);

      // streaming from reset: one instruction per cycle
      for (int k = 0; k < 10; k++) begin
         step(0, 0, 32'd0, 0);
         if (k == 0) check("first_issue_addr", s_addr, 32'd0);
         if (k == 0) check("first_issue_mr", {31'd0, s_mr}, 32'd1);
         if (k == 1) check("second_issue_addr", s_addr, 32'd4);
         if (k == 1) check("no_valid_cycle1", {31'd0, s_valid}, 32'd0);
         if (k >= 2) begin
            check("stream_valid", {31'd0, s_valid}, 32'd1);
            check("stream_pc", s_pc, 32'((k - 2) * 4));
            check("stream_instr", s_instr, 32'(k - 2));
         end
      end

      // five stalled cycles: head frozen at pc 32, no further requests
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 32'd0, 1);
         check("stall_pc", s_pc, 32'd32);
         check("stall_instr", s_instr, 32'd8);
         check("stall_mr", {31'd0, s_mr}, 32'd0);
      end
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 32'd0, 0);
         check("release_pc", s_pc, 32'(32 + 4 * k));
      end

      // redirect to 0x4000 with a response in flight, also stalled
      step(0, 1, 32'h4000, 1);
      step(0, 0, 32'd0, 0);
      check("redir_addr", s_addr, 32'h4000);
      check("redir_mr", {31'd0, s_mr}, 32'd1);
      check("redir_flushed", {31'd0, s_valid}, 32'd0);
      step(0, 0, 32'd0, 0);
      check("redir_dropped", {31'd0, s_valid}, 32'd0);
      step(0, 0, 32'd0, 0);
      check("redir_valid", {31'd0, s_valid}, 32'd1);
      check("redir_pc", s_pc, 32'h4000);
      check("redir_instr", s_instr, 32'h1000);
      repeat (3) step(0, 0, 32'd0, 0);

      // misaligned redirect target faults; a later redirect clears it
      step(0, 1, 32'h0102, 0);
      step(0, 0, 32'd0, 0);
      check("mis_mr", {31'd0, s_mr}, 32'd0);
      step(0, 0, 32'd0, 0);
      check("mis_fault", {31'd0, s_fault}, 32'd1);
      check("mis_fpc", s_fpc, 32'h0102);
      repeat (3) step(0, 0, 32'd0, 0);
      check("mis_fault_sticky", {31'd0, s_fault}, 32'd1);
      check("mis_mr_sticky", {31'd0, s_mr}, 32'd0);
      step(0, 1, 32'h0100, 0);
      step(0, 0, 32'd0, 0);
      check("clr_fault", {31'd0, s_fault}, 32'd0);
      check("clr_fpc", s_fpc, 32'd0);
      check("clr_addr", s_addr, 32'h0100);
      step(0, 0, 32'd0, 0);
      step(0, 0, 32'd0, 0);
      check("clr_pc", s_pc, 32'h0100);

      // sequential fetch up to the end of code memory
      step(0, 1, 32'h5FF8, 0);
      step(0, 0, 32'd0, 0);
      check("top_addr0", s_addr, 32'h5FF8);
      step(0, 0, 32'd0, 0);
      check("top_addr1", s_addr, 32'h5FFC);
      step(0, 0, 32'd0, 0);
      check("top_no_issue", {31'd0, s_mr}, 32'd0);
      check("top_addr_hold", s_addr, 32'h5FFC);
      check("top_pc0", s_pc, 32'h5FF8);
      step(0, 0, 32'd0, 0);
      check("top_fault", {31'd0, s_fault}, 32'd1);
      check("top_fpc", s_fpc, 32'h6000);
      check("top_pc1", s_pc, 32'h5FFC);
      check("top_instr1", s_instr, 32'h17FF);
      step(0, 0, 32'd0, 0);
      check("top_drained", {31'd0, s_valid}, 32'd0);

      // reset mid-stream, together with a redirect
      step(0, 1, 32'h0200, 0);
      repeat (4) step(0, 0, 32'd0, 0);
      step(0, 0, 32'd0, 1);
      step(1, 1, 32'h0300, 0);
      step(1, 0, 32'd0, 0);
      check("rst2_valid", {31'd0, s_valid}, 32'd0);
      check("rst2_mr", {31'd0, s_mr}, 32'd0);
      step(0, 0, 32'd0, 0);
      check("rst2_addr", s_addr, RESET_PC);
      step(0, 0, 32'd0, 0);
      step(0, 0, 32'd0, 0);
      check("rst2_pc", s_pc, RESET_PC);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int r;
         bit rst_b, redir_b, stall_b;
         r       = $urandom_range(0, 999);
         rst_b   = (r < 4);
         redir_b = (r < 40);
         stall_b = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 25 : 60));
         step(rst_b, redir_b, rand_target(), stall_b);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
